f2i_conv_seq: RTL and testbench
===============================

Name: f2i_conv_seq

Overview:
Parametrised, multi-cycle floating-point to sign-magnitude integer converter. It generalises the fixed half-precision converter to any exponent, mantissa and integer width. It uses a start/busy/done handshake and a serial one-bit-per-cycle aligner in place of a full barrel shifter. It sits beside data_mem as a coprocessor: the CPU or bench loads the operand, pulses start, and reads the result after done.

Parameters:
EXP_W, 5, exponent field width
MAN_W, 10, stored mantissa width (hidden bit not stored)
BIAS, 15, exponent bias
INT_W, 16, result width; bit INT_W-1 is the sign, the rest is magnitude
CNT_W, 5, shift counter width; must hold max(MAN_W+1, INT_W-2-MAN_W)

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  request a conversion; accepted only when ready_o=1
flt_i  in  1+EXP_W+MAN_W  operand as {sign, exp, mant}; sampled on the accepting edge
ready_o  out  1  high in IDLE
busy_o  out  1  high from the accepting edge until done
done_o  out  1  one-cycle pulse when int_o is valid
int_o  out  INT_W  result; held until the next accepted start

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, ready_o=1, busy_o=0, done_o=0, int_o=0. Reset mid-conversion aborts the conversion and clears all outputs; no done pulse follows.
- States and transitions:
  - IDLE -> DECODE on start_i.
  - DECODE -> SHIFT if k>0, otherwise -> ROUND.
  - SHIFT repeats k edges, then -> ROUND.
  - ROUND -> IDLE; this edge loads int_o and sets done_o for exactly one cycle.
- start_i is ignored while busy_o=1. A start_i in the same cycle done_o=1 is accepted, because ready_o=1 then.
- Latency: done_o rises k+2 edges after the accepting edge.
- DECODE, with e = exp - BIAS and sig = {1, mant} (MAN_W+1 bits):
  - exp==0: zero; denormals flush to 0. k=0.
  - exp==all-ones, or e >= INT_W-1: saturate. Magnitude = 2^(INT_W-1)-1. k=0.
  - e < -1: result 0, k=0.
  - e >= MAN_W: left shift, k = e-MAN_W. No rounding.
  - -1 <= e < MAN_W: right shift, k = MAN_W-e.
- Right shift, per cycle: guard <= sig LSB; sticky <= sticky | old guard.
- ROUND: round to nearest, ties to even. Increment if guard && (sticky || LSB). A round-up carry can never exceed the magnitude range, because e <= INT_W-2.
- Sign bit:
  - copied from flt_i for every case, including zero and saturation.
  - negative zero is therefore 1 followed by all zeros.
  - saturation on a negative operand gives 1 followed by all ones.
- For the default parameters, results are bit-identical to the existing 16-bit converter.

Optional Feature:
F2I_FLAGS_EN
- Defined: adds outputs ovf_o and inexact_o, each 1 bit.
  - Both are valid with done_o and held with int_o; both reset to 0.
  - ovf_o=1 on saturation.
  - inexact_o=1 when guard|sticky was set, or on a nonzero operand that underflowed to zero.
- Undefined: these ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset, then flt_i=0x3C00 (1.0) with one start pulse -> int_o=0x0001; done_o exactly 12 edges after acceptance (k=10); busy_o high throughout.
- Rounding, one start each -> 0x3E00 (1.5) gives 0x0002; 0x4100 (2.5) gives 0x0002 (tie to even); 0x3800 (0.5) gives 0x0000; 0x3801 gives 0x0001; 0xC500 (-5.0) gives 0x8005.
- Large values -> 0x7400 gives 0x4000 (left shift, done after 6 edges); 0x7800 and 0xFBFF give 0x7FFF and 0xFFFF (saturated, done after 2 edges); with F2I_FLAGS_EN, ovf_o=1.
- Underflow -> 0x0001 (denormal) and 0x3000 both give 0x0000 after 2 edges; 0x8000 gives 0x8000.
- Handshake -> extra start_i pulses while busy change nothing; start_i held through done gives back-to-back conversions with no lost cycle.
- reset_i asserted mid-SHIFT -> outputs clear asynchronously, no done pulse; the next conversion after reset is correct.
- INT_W=32, EXP_W=8, MAN_W=23, BIAS=127 -> 0x4B000001 gives 0x00800001; 0x4F000000 gives 0x7FFFFFFF.

Source files
------------

// File: rtl/f2i_conv_seq.sv
// Multi-cycle float -> sign-magnitude integer converter with start/busy/done handshake
// and a one-bit-per-cycle aligner. Define F2I_FLAGS_EN to add ovf_o / inexact_o.
module f2i_conv_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15,
  parameter int INT_W = 16,
  parameter int CNT_W = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [EXP_W+MAN_W:0]     flt_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [INT_W-1:0]         int_o
`ifdef F2I_FLAGS_EN
  ,
  output logic                     ovf_o,
  output logic                     inexact_o
`endif
);

  localparam int FLT_W = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int MAG_W = INT_W - 1;
  localparam int ACC_W = (SIG_W > MAG_W) ? SIG_W : MAG_W;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_SHIFT, S_ROUND} state_t;

  state_t             state_q, state_d;
  logic [FLT_W-1:0]   op_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               guard_q, sticky_q, left_q;

  logic               op_sign;
  logic [EXP_W-1:0]   op_exp;
  logic [MAN_W-1:0]   op_man;
  logic [SIG_W-1:0]   sig;
  int                 e_val;

  assign op_sign = op_q[FLT_W-1];
  assign op_exp  = op_q[FLT_W-2 -: EXP_W];
  assign op_man  = op_q[MAN_W-1:0];
  assign sig     = {1'b1, op_man};
  assign e_val   = int'(op_exp) - BIAS;

  // Decode: classify the operand and choose the initial aligner contents and shift count.
  logic [ACC_W-1:0]   dec_acc;
  logic [CNT_W-1:0]   dec_k;
  logic               dec_left;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    dec_acc  = '0;
    dec_k    = '0;
    dec_left = 1'b1;
    if (op_exp == '0) begin
      dec_acc = '0;
    end else if (op_exp == '1 || e_val >= INT_W - 1) begin
      dec_acc = ACC_W'({MAG_W{1'b1}});
    end else if (e_val < -1) begin
      dec_acc = '0;
    end else if (e_val >= MAN_W) begin
      dec_acc = ACC_W'(sig);
      dec_k   = CNT_W'(e_val - MAN_W);
    end else begin
      dec_acc  = ACC_W'(sig);
      dec_k    = CNT_W'(MAN_W - e_val);
      dec_left = 1'b0;
    end
  end

  // Round to nearest, ties to even; e <= INT_W-2 guarantees the carry stays in range.
  logic               round_up;
  logic [MAG_W-1:0]   mag_rnd;

  assign round_up = guard_q & (sticky_q | acc_q[0]);
  assign mag_rnd  = acc_q[MAG_W-1:0] + MAG_W'(round_up);

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    busy_o  = 1'b1;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (start_i) state_d = S_DECODE;
      end
      S_DECODE: state_d = (dec_k != '0) ? S_SHIFT : S_ROUND;
      S_SHIFT:  if (cnt_q == CNT_W'(1)) state_d = S_ROUND;
      S_ROUND:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      left_q   <= 1'b0;
      int_o    <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) op_q <= flt_i;
        S_DECODE: begin
          acc_q    <= dec_acc;
          cnt_q    <= dec_k;
          left_q   <= dec_left;
          guard_q  <= 1'b0;
          sticky_q <= 1'b0;
        end
        S_SHIFT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (left_q) begin
            acc_q <= acc_q << 1;
          end else begin
            acc_q    <= acc_q >> 1;
            guard_q  <= acc_q[0];
            sticky_q <= sticky_q | guard_q;
          end
        end
        S_ROUND: begin
          int_o  <= {op_sign, mag_rnd};
          done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef F2I_FLAGS_EN
  // Flags: saturation and inexactness, captured in DECODE and published with int_o.
  logic dec_sat, dec_uf, sat_q, uf_q;

  assign dec_sat = (op_exp == '1) || ((op_exp != '0) && (e_val >= INT_W - 1));
  assign dec_uf  = (op_exp == '0) ? (op_man != '0) : (!dec_sat && (e_val < -1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sat_q     <= 1'b0;
      uf_q      <= 1'b0;
      ovf_o     <= 1'b0;
      inexact_o <= 1'b0;
    end else if (state_q == S_DECODE) begin
      sat_q <= dec_sat;
      uf_q  <= dec_uf;
    end else if (state_q == S_ROUND) begin
      ovf_o     <= sat_q;
      inexact_o <= guard_q | sticky_q | uf_q;
    end
  end
`endif

endmodule

// File: tb/tb_f2i_conv_seq.sv
// Directed self-checking bench for f2i_conv_seq: default half-precision instance plus a
// single-precision / 32-bit instance, with a scoreboard queue of expected results.
module tb_f2i_conv_seq;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_i, start_i;
  logic [15:0] flt_i;
  logic        ready_o, busy_o, done_o;
  logic [15:0] int_o;

  logic        w_start;
  logic [31:0] w_flt;
  logic        w_ready, w_busy, w_done;
  logic [31:0] w_int;

`ifdef F2I_FLAGS_EN
  logic ovf_o, inexact_o, w_ovf, w_inexact;
`endif

  f2i_conv_seq dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .flt_i(flt_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .int_o(int_o)
`ifdef F2I_FLAGS_EN
    , .ovf_o(ovf_o), .inexact_o(inexact_o)
`endif
  );

  f2i_conv_seq #(.EXP_W(8), .MAN_W(23), .BIAS(127), .INT_W(32), .CNT_W(5)) dut_w (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(w_start), .flt_i(w_flt),
    .ready_o(w_ready), .busy_o(w_busy), .done_o(w_done), .int_o(w_int)
`ifdef F2I_FLAGS_EN
    , .ovf_o(w_ovf), .inexact_o(w_inexact)
`endif
  );

  typedef struct {
    logic [31:0] val;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for done on the narrow instance, counting edges after the accepting edge.
  task automatic wait_done(input bit poke, input bit keep, input string tag);
    exp_t e;
    int   lat = 0;
    bit   got = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        got = 1'b1;
        lat = i;
        break;
      end
      check({tag, "_busy"}, 32'(busy_o), 32'd1);
      if (poke) begin
        start_i = i[0];
        flt_i   = 16'($urandom);
      end
    end
    if (!keep) start_i = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      check({tag, "_int"}, 32'(int_o), e.val);
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
      check({tag, "_ready_at_done"}, 32'(ready_o), 32'd1);
`ifdef F2I_FLAGS_EN
      check({tag, "_ovf"}, 32'(ovf_o), 32'(e.val[14:0] == 15'h7fff));
`endif
    end
  endtask

  task automatic run(input logic [15:0] f, input logic [15:0] e, input int lat,
                     input bit poke, input string tag);
    @(posedge clk_i); #1;
    flt_i   = f;
    start_i = 1'b1;
    sb.push_back('{32'(e), lat});
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (poke) flt_i = 16'hffff;
    wait_done(poke, 1'b0, tag);
  endtask

  task automatic run_w(input logic [31:0] f, input logic [31:0] e, input int lat,
                       input string tag);
    exp_t x;
    int   got_lat = 0;
    @(posedge clk_i); #1;
    w_flt   = f;
    w_start = 1'b1;
    sb.push_back('{e, lat});
    @(posedge clk_i); #1;
    w_start = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk_i); #1;
      if (w_done) begin
        got_lat = i;
        break;
      end
    end
    x = sb.pop_front();
    check({tag, "_latency"}, 32'(got_lat), 32'(x.lat));
    check({tag, "_int"}, w_int, x.val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_done;
    reset_i = 1'b1;
    start_i = 1'b0;
    flt_i   = '0;
    w_start = 1'b0;
    w_flt   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_done",  32'(done_o),  32'd0);
    check("rst_int",   32'(int_o),   32'd0);
    reset_i = 1'b0;

    run(16'h3c00, 16'h0001, 12, 1'b0, "one");
    run(16'h3e00, 16'h0002, 12, 1'b0, "one_half");
    run(16'h4100, 16'h0002, 11, 1'b0, "two_half_tie");
    run(16'h3800, 16'h0000, 13, 1'b0, "half_tie");
    run(16'h3801, 16'h0001, 13, 1'b0, "half_plus");
    run(16'h7400, 16'h4000, 6,  1'b0, "left_shift");
    run(16'h7800, 16'h7fff, 2,  1'b0, "sat_pos");
    run(16'hfbff, 16'hffff, 2,  1'b0, "sat_neg");
    run(16'h0001, 16'h0000, 2,  1'b0, "denormal");
    run(16'h3000, 16'h0000, 2,  1'b0, "underflow");
    run(16'h8000, 16'h8000, 2,  1'b0, "neg_zero");
    run(16'h4100, 16'h0002, 11, 1'b1, "ignore_busy_start");

    // Back-to-back: start held through done, second operand accepted on the done edge.
    @(posedge clk_i); #1;
    flt_i   = 16'h3e00;
    start_i = 1'b1;
    sb.push_back('{32'h0002, 12});
    @(posedge clk_i); #1;
    flt_i = 16'hc500;
    sb.push_back('{32'h8005, 10});
    wait_done(1'b0, 1'b1, "b2b_first");
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("b2b_accepted", 32'(busy_o), 32'd1);
    wait_done(1'b0, 1'b0, "b2b_second");

    // Reset in the middle of SHIFT aborts the conversion without a done pulse.
    @(posedge clk_i); #1;
    flt_i   = 16'h3c00;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #3 reset_i = 1'b1;
    #1;
    check("midrst_busy",  32'(busy_o),  32'd0);
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_done",  32'(done_o),  32'd0);
    check("midrst_int",   32'(int_o),   32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    n_done = 0;
    repeat (14) begin
      @(posedge clk_i); #1;
      if (done_o) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    run(16'h3c00, 16'h0001, 12, 1'b0, "after_reset");

    run_w(32'h4b000001, 32'h00800001, 2, "w_exact");
    run_w(32'h4f000000, 32'h7fffffff, 2, "w_sat");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
